// File: rtl/rr_grant_encoder.sv
// N-channel request arbiter (fixed priority or round-robin) holding one grant
// until release, presented as registered one-hot vector and binary index.
module rr_grant_encoder #(
  parameter int N     = 4,
  parameter int MODE  = 1,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             error
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             error_q, error_d;

  logic [N-1:0]     arb_vec;
  logic [IDX_W:0]   arb_res;
  logic             arb_found;
  logic [IDX_W-1:0] arb_idx;
  logic             release_req;

  // Circular search starting at start; MSB of result flags a hit.
  function automatic logic [IDX_W:0] pick(input logic [N-1:0] vec,
                                          input logic [IDX_W-1:0] start);
    logic             found;
    logic [IDX_W-1:0] idx;
    int               c;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      c = (int'(start) + k) % N;
      if (!found && vec[c[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = c[IDX_W-1:0];
      end
    end
    return {found, idx};
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] w);
    int t;
    t = int'(w) + 1;
    if (t >= N) t = 0;
    return t[IDX_W-1:0];
  endfunction

  // Idle arbitrates the raw request; a releasing grant arbitrates without itself.
  assign arb_vec     = (state_q == GRANT) ? (req & ~gnt_q) : req;
  assign arb_res     = pick(arb_vec, ptr_q);
  assign arb_found   = arb_res[IDX_W];
  assign arb_idx     = arb_res[IDX_W-1:0];
  assign release_req = done || !req[gnt_idx_q];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    error_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        error_d = done;
        if (en && arb_found) begin
          state_d          = GRANT;
          gnt_d            = '0;
          gnt_d[arb_idx]   = 1'b1;
          gnt_idx_d        = arb_idx;
          gnt_valid_d      = 1'b1;
          if (MODE != 0) ptr_d = next_ptr(arb_idx);
        end
      end
      GRANT: begin
        if (release_req) begin
          if (en && arb_found) begin
            gnt_d          = '0;
            gnt_d[arb_idx] = 1'b1;
            gnt_idx_d      = arb_idx;
            if (MODE != 0) ptr_d = next_ptr(arb_idx);
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      error_q     <= error_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign error     = error_q;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Bench for rr_grant_encoder: fixed-priority and round-robin instances share
// stimulus and are compared against a behavioural arbitration model.
module tb_rr_grant_encoder;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst, en, done;
  logic [3:0] req;

  logic [3:0] gnt_fp, gnt_rr;
  logic [1:0] idx_fp, idx_rr;
  logic       v_fp, v_rr, e_fp, e_rr;

  int checks = 0;
  int errors = 0;

  // Model state, index 0 = fixed priority, 1 = round-robin.
  bit m_valid [2];
  int m_idx   [2];
  int m_ptr   [2];
  bit m_err   [2];

  always #5 clk = ~clk;

  rr_grant_encoder #(.N(N), .MODE(0)) u_fp (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt_fp), .gnt_idx(idx_fp), .gnt_valid(v_fp), .error(e_fp)
  );

  rr_grant_encoder #(.N(N), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt_rr), .gnt_idx(idx_rr), .gnt_valid(v_rr), .error(e_rr)
  );

  function automatic int search(input logic [3:0] r, input int start);
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  task automatic model_edge();
    logic [3:0] masked;
    int w;
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        m_valid[m] = 0; m_idx[m] = 0; m_ptr[m] = 0; m_err[m] = 0;
      end else if (!m_valid[m]) begin
        m_err[m] = done;
        w = search(req, m_ptr[m]);
        if (en && w >= 0) begin
          m_valid[m] = 1; m_idx[m] = w;
          if (m == 1) m_ptr[m] = (w + 1) % N;
        end
      end else begin
        m_err[m] = 0;
        if (done || !req[m_idx[m]]) begin
          masked = req;
          masked[m_idx[m]] = 1'b0;
          w = search(masked, m_ptr[m]);
          if (en && w >= 0) begin
            m_idx[m] = w;
            if (m == 1) m_ptr[m] = (w + 1) % N;
          end else begin
            m_valid[m] = 0; m_idx[m] = 0;
          end
        end
      end
    end
  endtask

  // Expected {gnt, gnt_idx, gnt_valid, error} for model m.
  function automatic logic [7:0] exp_word(input int m);
    logic [3:0] g;
    logic [1:0] ix;
    g  = m_valid[m] ? (4'b0001 << m_idx[m]) : 4'b0000;
    ix = 2'(m_idx[m]);
    return {g, ix, m_valid[m], m_err[m]};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1; en = 0; req = '0; done = 0;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({gnt_rr, idx_rr, v_rr, e_rr} !== 8'h00) begin
      errors++; $display("FAIL reset_rr act=%h req=00", {gnt_rr, idx_rr, v_rr, e_rr});
    end
    checks++;
    if ({gnt_fp, idx_fp, v_fp, e_fp} !== 8'h00) begin
      errors++; $display("FAIL reset_fp act=%h req=00", {gnt_fp, idx_fp, v_fp, e_fp});
    end
    en = 1; req = 4'b0100;
    step();
    checks++;
    if (idx_rr !== 2'd2 || gnt_rr !== 4'b0100) begin
      errors++; $display("FAIL pre_reset_grant idx=%0d gnt=%b req idx=2 gnt=0100", idx_rr, gnt_rr);
    end
    rst = 1;
    step();
    rst = 0; en = 0; req = '0;
    checks++;
    if ({gnt_rr, idx_rr, v_rr, e_rr} !== 8'h00) begin
      errors++; $display("FAIL reset_mid_grant act=%h req=00", {gnt_rr, idx_rr, v_rr, e_rr});
    end
    // ptr back at 0: full request must be granted to channel 0.
    en = 1; req = 4'b1111;
    step();
    checks++;
    if (idx_rr !== 2'd0 || v_rr !== 1'b1) begin
      errors++; $display("FAIL reset_ptr idx=%0d v=%b req idx=0 v=1", idx_rr, v_rr);
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    en = 1; req = 4'b1010;
    step();
    checks++;
    if (gnt_fp !== 4'b0010 || idx_fp !== 2'd1) begin
      errors++; $display("FAIL fp_first gnt=%b idx=%0d req gnt=0010 idx=1", gnt_fp, idx_fp);
    end
    done = 1;
    step();
    checks++;
    if (gnt_fp !== 4'b1000 || idx_fp !== 2'd3 || v_fp !== 1'b1) begin
      errors++; $display("FAIL fp_b2b gnt=%b idx=%0d v=%b req gnt=1000 idx=3 v=1", gnt_fp, idx_fp, v_fp);
    end
    req = 4'b0000;
    step();
    done = 0;
    checks++;
    if (v_fp !== 1'b0 || gnt_fp !== 4'b0000) begin
      errors++; $display("FAIL fp_release v=%b gnt=%b req v=0 gnt=0000", v_fp, gnt_fp);
    end
    checks++;
    if ({gnt_rr, idx_rr, v_rr, e_rr} !== exp_word(1)) begin
      errors++; $display("FAIL fp_rr_model act=%h req=%h", {gnt_rr, idx_rr, v_rr, e_rr}, exp_word(1));
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    en = 1; req = 4'b1111;
    step();
    checks++;
    if (idx_rr !== 2'd0 || v_rr !== 1'b1) begin
      errors++; $display("FAIL rr_start idx=%0d v=%b req idx=0 v=1", idx_rr, v_rr);
    end
    done = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (idx_rr !== seq[i] || v_rr !== 1'b1 || gnt_rr !== (4'b0001 << seq[i])) begin
        errors++; $display("FAIL rr_seq%0d idx=%0d v=%b gnt=%b req idx=%0d v=1", i, idx_rr, v_rr, gnt_rr, seq[i]);
      end
    end
    done = 0;
  endtask

  task automatic test_wrap_skip();
    do_reset();
    en = 1; req = 4'b0100;
    step();
    req = 4'b0101; done = 1;
    step();
    checks++;
    if (idx_rr !== 2'd0 || v_rr !== 1'b1) begin
      errors++; $display("FAIL wrap idx=%0d v=%b req idx=0 v=1", idx_rr, v_rr);
    end
    step();
    done = 0;
    checks++;
    if (idx_rr !== 2'd2 || gnt_rr !== 4'b0100) begin
      errors++; $display("FAIL skip idx=%0d gnt=%b req idx=2 gnt=0100", idx_rr, gnt_rr);
    end
  endtask

  task automatic test_drop_en();
    do_reset();
    en = 1; req = 4'b0010;
    step();
    checks++;
    if (idx_rr !== 2'd1) begin
      errors++; $display("FAIL drop_grant idx=%0d req 1", idx_rr);
    end
    en = 0; req = 4'b1100;
    step();
    checks++;
    if (v_rr !== 1'b0 || gnt_rr !== 4'b0000 || idx_rr !== 2'd0) begin
      errors++; $display("FAIL drop_idle v=%b gnt=%b idx=%0d req v=0 gnt=0000 idx=0", v_rr, gnt_rr, idx_rr);
    end
    en = 1;
    step();
    checks++;
    if (idx_rr !== 2'd2 || v_rr !== 1'b1) begin
      errors++; $display("FAIL en_regrant idx=%0d v=%b req idx=2 v=1", idx_rr, v_rr);
    end
  endtask

  task automatic test_error();
    do_reset();
    done = 1;
    step();
    done = 0;
    checks++;
    if (e_rr !== 1'b1 || v_rr !== 1'b0) begin
      errors++; $display("FAIL err_pulse e=%b v=%b req e=1 v=0", e_rr, v_rr);
    end
    step();
    checks++;
    if (e_rr !== 1'b0 || e_fp !== 1'b0) begin
      errors++; $display("FAIL err_clear e_rr=%b e_fp=%b req 0", e_rr, e_fp);
    end
    done = 1; en = 1; req = 4'b0001;
    step();
    done = 0;
    checks++;
    if (e_fp !== 1'b1 || v_fp !== 1'b1 || idx_fp !== 2'd0) begin
      errors++; $display("FAIL err_with_grant e=%b v=%b idx=%0d req e=1 v=1 idx=0", e_fp, v_fp, idx_fp);
    end
    step();
    checks++;
    if (e_fp !== 1'b0 || v_fp !== 1'b1) begin
      errors++; $display("FAIL err_in_grant e=%b v=%b req e=0 v=1", e_fp, v_fp);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 39) == 0);
      en   = ($urandom_range(0, 3) != 0);
      done = ($urandom_range(0, 2) == 0);
      req  = 4'($urandom);
      step();
      checks++;
      if ({gnt_fp, idx_fp, v_fp, e_fp} !== exp_word(0)) begin
        errors++; $display("FAIL rand_fp cyc=%0d act=%h req=%h", i, {gnt_fp, idx_fp, v_fp, e_fp}, exp_word(0));
      end
      checks++;
      if ({gnt_rr, idx_rr, v_rr, e_rr} !== exp_word(1)) begin
        errors++; $display("FAIL rand_rr cyc=%0d act=%h req=%h", i, {gnt_rr, idx_rr, v_rr, e_rr}, exp_word(1));
      end
      checks++;
      if (!$onehot0(gnt_rr) || !$onehot0(gnt_fp)) begin
        errors++; $display("FAIL rand_onehot cyc=%0d fp=%b rr=%b req at most one bit", i, gnt_fp, gnt_rr);
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; en = 0; req = '0; done = 0;
    foreach (m_valid[m]) begin
      m_valid[m] = 0; m_idx[m] = 0; m_ptr[m] = 0; m_err[m] = 0;
    end
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_wrap_skip();
    test_drop_en();
    test_error();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_grant_encoder.md
# rr_grant_encoder

Parametrised N-channel request arbiter with a registered grant encoder and decoder. Each cycle it selects one active request by fixed priority or round-robin order. It holds that grant until release and presents the winner both as a one-hot vector and as a binary index, with a protocol-error flag. It sits between N requesters and a shared resource, in the same combinational encoder/decoder/mux family the team already uses, and adds clocked arbitration state.

## Interface
- N, 4: number of request channels (≥2).
- MODE, 1: 0 = fixed priority (lowest index wins); 1 = round-robin.
- IDX_W, $clog2(N): derived localparam, width of the grant index.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  permits new grants; an existing grant is unaffected.
- req  in  N  request vector, bit i = channel i.
- done  in  1  releases the current grant.
- gnt  out  N  one-hot grant, registered.
- gnt_idx  out  IDX_W  binary index of granted channel, registered; 0 when no grant.
- gnt_valid  out  1  a grant is active.
- error  out  1  one-cycle pulse on protocol error.

## Operation
- State machine states:
  - IDLE: no grant held.
  - GRANT: one grant held.
- Internal round-robin pointer ptr, IDX_W bits.
- Arbitration search order:
  - Search starts at ptr and proceeds ptr, ptr+1, … N-1, 0, … ptr-1, with modulo-N wrap.
  - In MODE=0, ptr is held at 0.
  - The first set bit in search order wins.
- IDLE → GRANT: en=1 and req≠0 at edge t.
  - gnt, gnt_idx and gnt_valid update at edge t.
  - In MODE=1, ptr becomes (winner+1) mod N.
- IDLE with req=0 or en=0: remain in IDLE; outputs stay 0.
- Release condition in GRANT: done=1 OR req[gnt_idx]=0.
- On release, re-arbitrate over req with bit gnt_idx masked out.
  - If en=1 and the masked vector ≠0, stay in GRANT and switch directly to the new winner. This is a back-to-back grant with no idle cycle. ptr updates as above.
  - Otherwise go to IDLE; gnt, gnt_idx and gnt_valid clear at that edge.
- No release condition in GRANT: outputs hold. Other requests and en are ignored.
- Invariants:
  - gnt is always the exact decode of gnt_idx when gnt_valid=1.
  - gnt = 0 when gnt_valid=0.
  - gnt has at most one bit set.
- Errors: error pulses for one cycle when done=1 is sampled in IDLE.
  - The error does not change state.
  - Only done with no active grant raises error.
- Reset, including mid-grant:
  - state = IDLE, ptr = 0.
  - gnt, gnt_idx, gnt_valid and error all = 0 after the reset edge.
  - rst has priority over all other inputs.

## Timing
- Grant latency: a request sampled at edge t gives valid outputs after edge t; 1 cycle.
- Release latency: done sampled at edge t means the grant changes or clears after edge t.
- Back-to-back handover: 0 idle cycles.
- error is registered: it is asserted in the cycle after the offending done is sampled.
- Outputs depend only on registers; there is no combinational input-to-output path.
- Simultaneous events:
  - done together with a dropped req counts as one release.
  - done in the same cycle as the grant-forming edge in IDLE raises error, and the grant still forms.

## Test plan
- Reset mid-grant: N=4, holding grant idx 2, assert rst one cycle → next cycle gnt=0000, gnt_idx=0, gnt_valid=0, error=0, ptr=0.
- Fixed priority, MODE=0: req=1010, en=1 → after 1 edge gnt=0010, gnt_idx=1.
  - Then done → gnt=1000, idx=3 with no idle cycle.
  - Then done with req=0000 → gnt_valid=0.
- Round-robin fairness, MODE=1: req=1111 held, done pulsed every cycle → gnt_idx sequence 0,1,2,3,0 with gnt_valid held at 1.
- Wrap and skip, MODE=1: ptr=3 after grant to idx 2, req=0101 → grant idx 0; next release grants idx 2.
- Request drop and en gating: grant idx 1, deassert req[1] with en=0 and req=1100 → IDLE next cycle. Raise en → gnt_idx=2 one cycle later.
- Protocol error: in IDLE assert done for one cycle → error=1 exactly one cycle, gnt_valid stays 0.
